dmem_arbiter: RTL

- Shares the single-port data RAM between two requesters: the core load/store path (port C) and a debug/loader port (port D).
- Port D is used for program/data download and inspection.
- Sits between the core's memory outputs and the RAM instance; the core write-back mux takes read data from c_rdata.
- Per-cycle grant with core priority, a starvation guard for D, and routing of the RAM's 1-cycle-latency read data back to the requester that issued the read.

---
 rtl/dmem_arb_pkg.sv | 14 +
 rtl/dmem_arbiter.sv | 99 +++++++++
 2 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and default widths for the data-RAM arbiter.
// Read-owner encoding tracks which port issued the read in flight.
package dmem_arb_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_C,
        OWN_D
    } rd_owner_t;

endpackage

// File: rtl/dmem_arbiter.sv
// Single-port data RAM arbiter: core priority, debug starvation guard,
// and 1-cycle read-data routing back to the issuing port.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_MAX = 4
) (
    input  logic              CLOCK,
    input  logic              RST,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              ram_we,
    output logic              ram_re,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

    logic [CW-1:0]     starve_cnt;
    rd_owner_t         rd_owner;
    logic [DATA_W-1:0] c_hold;
    logic [DATA_W-1:0] d_hold;
    logic              force_d;

    always_comb begin
        force_d  = (STARVE_MAX != 0) && (starve_cnt == SMAX);
        d_gnt    = !RST && d_req && (!c_req || force_d);
        c_gnt    = !RST && c_req && !d_gnt;
        ram_addr = '0;
        ram_din  = '0;
        ram_we   = 1'b0;
        ram_re   = 1'b0;
        unique case (1'b1)
            d_gnt: begin
                ram_addr = d_addr;
                ram_din  = d_wdata;
                ram_we   = d_we;
                ram_re   = !d_we;
            end
            c_gnt: begin
                ram_addr = c_addr;
                ram_din  = c_wdata;
                ram_we   = c_we;
                ram_re   = !c_we;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RST) begin
            starve_cnt <= '0;
            rd_owner   <= OWN_NONE;
            c_hold     <= '0;
            d_hold     <= '0;
        end else begin
            if (d_req && !d_gnt) begin
                if (starve_cnt != SMAX)
                    starve_cnt <= starve_cnt + CW'(1);
            end else begin
                starve_cnt <= '0;
            end
            if (c_gnt && !c_we)
                rd_owner <= OWN_C;
            else if (d_gnt && !d_we)
                rd_owner <= OWN_D;
            else
                rd_owner <= OWN_NONE;
            // Capture the delivered word so rdata holds after the pulse.
            if (rd_owner == OWN_C)
                c_hold <= ram_dout;
            if (rd_owner == OWN_D)
                d_hold <= ram_dout;
        end
    end

    assign c_rvalid = (rd_owner == OWN_C);
    assign d_rvalid = (rd_owner == OWN_D);
    assign c_rdata  = c_rvalid ? ram_dout : c_hold;
    assign d_rdata  = d_rvalid ? ram_dout : d_hold;

endmodule
